matrix_serial_tx: RTL and testbench

Bit-serial matrix transmitter that feeds the 4x4 matrix multiplier. It accepts one pair of parallel 4x4 operand matrices (A and B) through a valid/ready load port. It then streams both matrices, in lock-step, onto two single-bit serial lines with a frame marker and a downstream enable. It sits directly upstream of the multiplier's serial A/B inputs and is the transmitting end of that serial operand interface.

---
 rtl/matrix_pkg.sv | 30 +++
 rtl/piso_shift.sv | 37 +++
 rtl/matrix_serial_tx.sv | 121 ++++++++++++
 tb/tb_matrix_serial_tx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and packing helper for the serial matrix
// transmitter and its shift registers.
package matrix_pkg;

  localparam int DATA_W     = 16;
  localparam int N          = 4;
  localparam int ELEMS      = N * N;
  localparam int FRAME_BITS = ELEMS * DATA_W;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } tx_state_t;

  // Element 0 must leave first, so it is placed in the most significant slot
  // of the shift storage; each element keeps its own MSB-first bit order.
  function automatic logic [FRAME_BITS-1:0] stream_order(
    input logic [FRAME_BITS-1:0] mat
  );
    logic [FRAME_BITS-1:0] s;
    s = '0;
    for (int k = 0; k < ELEMS; k++) begin
      s[(ELEMS-1-k)*DATA_W +: DATA_W] = mat[k*DATA_W +: DATA_W];
    end
    return s;
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in / serial-out shift register, MSB first, zero-filling from the
// bottom so the serial output returns to 0 once the whole word has left.
module piso_shift #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             serial_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // Taken straight from a flop, so the serial line is registered.
  assign serial_o = sr_q[WIDTH-1];

endmodule

// File: rtl/matrix_serial_tx.sv
// Bit-serial transmitter for a pair of 4x4 operand matrices: captures A and B
// over a valid/ready port and streams them in lock-step with frame marker.
module matrix_serial_tx
  import matrix_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [FRAME_BITS-1:0]    load_a,
  input  logic [FRAME_BITS-1:0]    load_b,
  input  logic                     tx_en,
  output logic                     tx_a_serial,
  output logic                     tx_b_serial,
  output logic                     tx_frame,
  output logic                     tx_active,
  output logic                     tx_done,
  output tx_state_t                dbg_state_o
);

  // Load handshake: a pair is transferred on a rising edge where load_valid
  // and load_ready are both 1; load_ready is only ever high in IDLE, and
  // load_valid in any other state is ignored without acknowledgement.

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             frame_q, frame_d;
  logic             active_q, active_d;
  logic             done_q, done_d;

  logic             accept;
  logic             shift;
  logic             last_bit;

  assign accept   = (state_q == IDLE) && load_valid && ready_q;
  assign shift    = (state_q == SEND) && tx_en;
  assign last_bit = (cnt_q == CNT_W'(FRAME_BITS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          cnt_d   = '0;
          frame_d = 1'b1;
        end
      end
      SEND: begin
        if (tx_en) begin
          frame_d = 1'b0;
          if (last_bit) begin
            state_d = DONE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        frame_d = 1'b0;
      end
    endcase
    // Status flags are registered copies of the next state.
    ready_d  = (state_d == IDLE);
    active_d = (state_d == SEND);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      frame_q  <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      frame_q  <= frame_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  piso_shift #(.WIDTH(FRAME_BITS)) u_piso_a (
    .clk      (clk),
    .rst      (rst),
    .load_i   (accept),
    .shift_i  (shift),
    .data_i   (stream_order(load_a)),
    .serial_o (tx_a_serial)
  );

  piso_shift #(.WIDTH(FRAME_BITS)) u_piso_b (
    .clk      (clk),
    .rst      (rst),
    .load_i   (accept),
    .shift_i  (shift),
    .data_i   (stream_order(load_b)),
    .serial_o (tx_b_serial)
  );

  assign load_ready  = ready_q;
  assign tx_frame    = frame_q;
  assign tx_active   = active_q;
  assign tx_done     = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_matrix_serial_tx.sv
// Directed bench for matrix_serial_tx: reassembles each serial frame and
// compares it with the parallel matrices that were offered.
module tb_matrix_serial_tx;
  import matrix_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [255:0] load_a = '0;
  logic [255:0] load_b = '0;
  logic         tx_en = 1'b1;
  logic         tx_a_serial;
  logic         tx_b_serial;
  logic         tx_frame;
  logic         tx_active;
  logic         tx_done;
  tx_state_t    dbg_state;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int acc_cyc   = 0;

  matrix_serial_tx dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_a      (load_a),
    .load_b      (load_b),
    .tx_en       (tx_en),
    .tx_a_serial (tx_a_serial),
    .tx_b_serial (tx_b_serial),
    .tx_frame    (tx_frame),
    .tx_active   (tx_active),
    .tx_done     (tx_done),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic checkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [255:0] mk_mat(input logic [15:0] base);
    logic [255:0] m;
    for (int k = 0; k < 16; k++) m[k*16 +: 16] = base + 16'(k);
    return m;
  endfunction

  // Expected serial bit b for each element/bit position, b indexes the result.
  function automatic logic [255:0] to_bits(input logic [255:0] m);
    logic [255:0] s;
    for (int k = 0; k < 16; k++)
      for (int bp = 0; bp < 16; bp++)
        s[k*16 + (15 - bp)] = m[k*16 + bp];
    return s;
  endfunction

  task automatic check_all_zero(input string tag);
    check1({tag, "_ready"},  load_ready,  1'b0);
    check1({tag, "_active"}, tx_active,   1'b0);
    check1({tag, "_frame"},  tx_frame,    1'b0);
    check1({tag, "_done"},   tx_done,     1'b0);
    check1({tag, "_a"},      tx_a_serial, 1'b0);
    check1({tag, "_b"},      tx_b_serial, 1'b0);
  endtask

  // Driver + receiver for one frame; returns early at bit abort_at.
  task automatic do_frame(input logic [255:0] a, input logic [255:0] b,
                          input int s0, input int s100, input bit intrude,
                          input int abort_at, input bit keep_valid);
    logic [255:0] got_a, got_b;
    bit frame_bad, active_bad, hold_bad;
    int guard, nst;
    got_a = '0; got_b = '0;
    frame_bad = 0; active_bad = 0; hold_bad = 0;
    load_a = a; load_b = b; load_valid = 1'b1;
    guard = 0;
    while (!load_ready && guard < 600) begin
      tick();
      guard++;
    end
    check1("accept_ready", load_ready, 1'b1);
    acc_cyc = cyc;
    tick();
    if (!keep_valid) load_valid = 1'b0;
    check1("ready_low_in_send", load_ready, 1'b0);
    check1("first_frame_marker", tx_frame, 1'b1);
    for (int bi = 0; bi < 256; bi++) begin
      if (bi == abort_at) return;
      if (tx_active !== 1'b1) active_bad = 1;
      if (tx_frame !== (bi == 0)) frame_bad = 1;
      got_a[bi] = tx_a_serial;
      got_b[bi] = tx_b_serial;
      if (intrude && bi == 50) begin
        load_valid = 1'b1; load_a = ~a; load_b = ~b;
        check1("intrude_ready_low", load_ready, 1'b0);
      end
      if ((bi == 0 && s0 > 0) || (bi == 100 && s100 > 0)) begin
        nst = (bi == 0) ? s0 : s100;
        tx_en = 1'b0;
        for (int s = 0; s < nst; s++) begin
          tick();
          if (tx_a_serial !== got_a[bi] || tx_b_serial !== got_b[bi] ||
              tx_frame !== (bi == 0) || tx_active !== 1'b1) hold_bad = 1;
        end
        tx_en = 1'b1;
      end
      tick();
      if (intrude && bi == 50) begin
        check1("intrude_ready_after", load_ready, 1'b0);
        load_valid = 1'b0; load_a = a; load_b = b;
      end
    end
    check1("done_pulse", tx_done, 1'b1);
    check1("done_active_low", tx_active, 1'b0);
    check1("done_frame_low", tx_frame, 1'b0);
    check1("done_a_zero", tx_a_serial, 1'b0);
    check1("done_b_zero", tx_b_serial, 1'b0);
    checki("done_latency", cyc - acc_cyc, 257 + s0 + s100);
    checkw("bits_a", got_a, to_bits(a));
    checkw("bits_b", got_b, to_bits(b));
    check1("frame_only_b0", frame_bad, 1'b0);
    check1("active_whole_send", active_bad, 1'b0);
    if (s0 + s100 > 0) check1("stall_hold", hold_bad, 1'b0);
    tick();
    check1("done_single_cycle", tx_done, 1'b0);
    check1("ready_after_done", load_ready, 1'b1);
    checki("state_idle_after", int'(dbg_state), int'(IDLE));
  endtask

  initial begin
    logic [255:0] ones;
    int first_acc;
    bit done_seen;
    ones = '1;

    // Reset behaviour
    rst = 1'b0;
    tick();
    tick();
    check_all_zero("in_reset");
    rst = 1'b1;
    tick();
    check1("ready_after_release", load_ready, 1'b1);
    checki("state_idle_reset", int'(dbg_state), int'(IDLE));

    // Unstalled frame
    do_frame(mk_mat(16'h1000), mk_mat(16'hF000), 0, 0, 0, -1, 0);

    // Stalls at b=0 (5 cycles) and b=100 (3 cycles)
    do_frame(mk_mat(16'h1000), mk_mat(16'hF000), 5, 3, 0, -1, 0);

    // load_valid with other data at b=50 is ignored
    do_frame(mk_mat(16'h1000), mk_mat(16'hF000), 0, 0, 1, -1, 0);

    // Reset at b=130 abandons the frame
    do_frame(mk_mat(16'h1000), mk_mat(16'hF000), 0, 0, 0, 130, 0);
    load_valid = 1'b0;
    rst = 1'b0;
    tick();
    check_all_zero("mid_reset");
    rst = 1'b1;
    tick();
    check1("ready_after_mid_reset", load_ready, 1'b1);
    done_seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (tx_done !== 1'b0) done_seen = 1;
      tick();
    end
    check1("no_done_after_abort", done_seen, 1'b0);
    do_frame(mk_mat(16'h3C00), mk_mat(16'h00C3), 0, 0, 0, -1, 0);

    // Back-to-back frames with load_valid held high
    do_frame(ones, '0, 0, 0, 0, -1, 1);
    first_acc = acc_cyc;
    do_frame('0, ones, 0, 0, 0, -1, 0);
    checki("b2b_period", acc_cyc - first_acc, 258);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
